// File: rtl/mt6835_spi_slave_emu.sv
// mt6835_spi_slave_emu
// SPI mode-3 responder emulating the MT6835 angle-register read interface.
// The transaction snapshot {i_angle, i_status} is latched at CS fall and
// served through a small register map (0x003..0x006). Burst reads
// auto-increment the address (12-bit wrap); single reads return 0x00 after
// the first byte.
//
// Build option: MT6835_CRC_EN - when defined, 0x006 returns CRC8 (poly 0x07,
// init 0x00, MSB first) over bytes 0x003..0x005 of the snapshot; otherwise
// 0x006 reads 0x00.
//
// Ports:
//   i_clk, i_rst_n        system clock, async active-low reset
//   i_angle[20:0]         live angle, sampled at transaction start
//   i_status[2:0]         live status, sampled with angle
//   i_spi_clk/cs/mosi     SPI inputs from master (CPOL=1, CS active low)
//   o_spi_miso, _oe       MISO data and output enable (data phase only)
//   o_busy                transaction in progress (synced CS low)
//   o_done                pulse at CS rise after >=1 complete data byte
//   o_cmd_err             pulse when the command nibble is unsupported
module mt6835_spi_slave_emu #(
  parameter logic [3:0]  CMD_BURST   = 4'hA,
  parameter logic [3:0]  CMD_SINGLE  = 4'h3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [20:0] i_angle,
  input  logic [2:0]  i_status,
  input  logic        i_spi_clk,
  input  logic        i_spi_cs,
  input  logic        i_spi_mosi,
  output logic        o_spi_miso,
  output logic        o_spi_miso_oe,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_cmd_err
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_IGNORE} state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic        r_sclk_prev, r_cs_prev;
  logic        w_sclk, w_cs, w_mosi;
  logic        w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;
  logic [14:0] r_cmd_sr;
  logic [15:0] w_word;
  logic        w_cmd_ok;
  logic [3:0]  r_bit_cnt;
  logic [11:0] r_addr;
  logic        r_burst;
  logic [7:0]  r_tx_sr;
  logic [7:0]  r_byte_cnt;
  logic [23:0] r_snapshot;
  logic [7:0]  w_crc;
  logic        r_miso, r_done, r_cmd_err;

  function automatic logic [7:0] f_reg_byte(input logic [11:0] addr,
                                            input logic [23:0] snap,
                                            input logic [7:0]  crc);
    f_reg_byte = '0;
    case (addr)
      12'h003: f_reg_byte = snap[23:16];
      12'h004: f_reg_byte = snap[15:8];
      12'h005: f_reg_byte = snap[7:0];
      12'h006: f_reg_byte = crc;
      default: f_reg_byte = '0;
    endcase
  endfunction

  // CS synchronizer resets to "low" with r_cs_prev low: a CS already low at
  // reset release produces no fall; it must be seen high first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk_sync <= '1;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b1;
      r_cs_prev   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_clk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      r_sclk_prev <= w_sclk;
      r_cs_prev   <= w_cs;
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_fall   = r_cs_prev & ~w_cs;
  assign w_cs_rise   = ~r_cs_prev & w_cs;
  // Gating with synced CS low also makes a coincident CS rise win.
  assign w_sclk_rise = ~r_sclk_prev & w_sclk & ~w_cs;
  assign w_sclk_fall = r_sclk_prev & ~w_sclk & ~w_cs;

  assign w_word   = {r_cmd_sr, w_mosi};
  assign w_cmd_ok = (w_word[15:12] == CMD_BURST) || (w_word[15:12] == CMD_SINGLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_rise) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_cs_fall) w_state_nxt = S_CMD;
        S_CMD:   if (w_sclk_rise && (r_bit_cnt == 4'd15))
                   w_state_nxt = w_cmd_ok ? S_DATA : S_IGNORE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd_sr   <= '0;
      r_bit_cnt  <= '0;
      r_addr     <= '0;
      r_burst    <= 1'b0;
      r_tx_sr    <= '0;
      r_byte_cnt <= '0;
      r_snapshot <= '0;
      r_miso     <= 1'b0;
      r_done     <= 1'b0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cmd_err <= 1'b0;
      if (w_cs_rise) begin
        r_miso     <= 1'b0;
        r_done     <= (r_byte_cnt != '0);
        r_byte_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (w_cs_fall) begin
            r_snapshot <= {i_angle, i_status};
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_miso     <= 1'b0;
          end
          S_CMD: if (w_sclk_rise) begin
            r_cmd_sr  <= w_word[14:0];
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd15) begin
              r_bit_cnt <= '0;
              if (w_cmd_ok) begin
                r_addr  <= w_word[11:0];
                r_burst <= (w_word[15:12] == CMD_BURST);
                r_tx_sr <= f_reg_byte(w_word[11:0], r_snapshot, w_crc);
              end else begin
                r_cmd_err <= 1'b1;
              end
            end
          end
          S_DATA: begin
            if (w_sclk_fall) begin
              r_miso  <= r_tx_sr[7];
              r_tx_sr <= {r_tx_sr[6:0], 1'b0};
            end else if (w_sclk_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt <= '0;
                if (r_byte_cnt != 8'hFF) r_byte_cnt <= r_byte_cnt + 8'd1;
                if (r_burst) begin
                  r_addr  <= r_addr + 12'd1;
                  r_tx_sr <= f_reg_byte(r_addr + 12'd1, r_snapshot, w_crc);
                end else begin
                  r_tx_sr <= '0;
                end
              end
            end
          end
          default: r_miso <= 1'b0;
        endcase
      end
    end
  end

`ifdef MT6835_CRC_EN
  // Bit-serial CRC8 over the 24 snapshot bits, one bit per i_clk starting the
  // cycle after CS fall; finishes long before the 16th command bit.
  logic [7:0] r_crc;
  logic [4:0] r_crc_idx;
  logic       r_crc_run;
  logic       w_crc_fb;

  assign w_crc_fb = r_crc[7] ^ r_snapshot[r_crc_idx];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_crc     <= '0;
      r_crc_idx <= '0;
      r_crc_run <= 1'b0;
    end else if ((r_state == S_IDLE) && w_cs_fall) begin
      r_crc     <= '0;
      r_crc_idx <= 5'd23;
      r_crc_run <= 1'b1;
    end else if (r_crc_run) begin
      r_crc <= {r_crc[6:0], 1'b0} ^ (w_crc_fb ? 8'h07 : 8'h00);
      if (r_crc_idx == '0) r_crc_run <= 1'b0;
      else                 r_crc_idx <= r_crc_idx - 5'd1;
    end
  end

  assign w_crc = r_crc;
`else
  assign w_crc = '0;
`endif

  assign o_spi_miso    = r_miso;
  assign o_spi_miso_oe = (r_state == S_DATA);
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;
  assign o_cmd_err     = r_cmd_err;

endmodule
